// File: rtl/a1339_poll_scheduler_if.sv
// SPI master handshake between the poll scheduler and the shared SPI engine.
// master = scheduler side, slave = SPI engine side.
interface a1339_poll_scheduler_if #(
  parameter int N = 1
);
  logic         spi_start;
  logic [15:0]  spi_cmd;
  logic [N-1:0] spi_sel;
  logic         spi_done;
  logic [15:0]  spi_rx;

  modport master (
    output spi_start,
    output spi_cmd,
    output spi_sel,
    input  spi_done,
    input  spi_rx
  );

  modport slave (
    input  spi_start,
    input  spi_cmd,
    input  spi_sel,
    output spi_done,
    output spi_rx
  );
endinterface

// File: rtl/a1339_poll_scheduler.sv
// Round-robin A1339 angle poller: one SPI read per sensor per sweep,
// frame check, multi-turn unwrap, zero offset and relative angle.
module a1339_poll_scheduler #(
  parameter int          NUMBER_OF_SENSORS = 1,
  parameter int          POLL_DIVIDER      = 50000,
  parameter int          TIMEOUT_CYCLES    = 1024,
  parameter logic [15:0] ANGLE_CMD         = 16'h2000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic zero_offset,
  a1339_poll_scheduler_if.master spi,
  output logic signed [31:0] sensor_angle              [NUMBER_OF_SENSORS],
  output logic signed [31:0] sensor_angle_absolute     [NUMBER_OF_SENSORS],
  output logic signed [31:0] sensor_angle_offset       [NUMBER_OF_SENSORS],
  output logic signed [31:0] sensor_angle_relative     [NUMBER_OF_SENSORS],
  output logic signed [31:0] sensor_revolution_counter [NUMBER_OF_SENSORS],
  output logic [NUMBER_OF_SENSORS-1:0] cycle,
  output logic [NUMBER_OF_SENSORS-1:0] error
);

  localparam int N  = NUMBER_OF_SENSORS;
  localparam int TW = $clog2(POLL_DIVIDER);
  localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] to_q, to_d;
  logic          bad_q, bad_d;
  logic [11:0]   raw_q, raw_d;
  logic          tick;

  logic [11:0]        ang_q [N];
  logic signed [31:0] abs_q [N];
  logic signed [31:0] off_q [N];
  logic signed [31:0] rel_q [N];
  logic signed [31:0] rev_q [N];
  logic [N-1:0]       cyc_q;
  logic [N-1:0]       err_q;
  logic [N-1:0]       seen_q;

  logic               unused_rx;
  assign unused_rx = ^{spi.spi_rx[14], spi.spi_rx[12]};

  assign tick   = (tick_q == TW'(POLL_DIVIDER - 1));
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    to_d    = to_q;
    bad_d   = bad_q;
    raw_d   = raw_q;
    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a timeout expiring in the same cycle
        if (spi.spi_done) begin
          bad_d   = spi.spi_rx[15] | spi.spi_rx[13];
          raw_d   = spi.spi_rx[11:0];
          state_d = S_UPDATE;
        end else if (to_q == OW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAIL;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_UPDATE, S_FAIL: state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q == IW'(N - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic sel_on;
  assign sel_on = (state_q == S_START) || (state_q == S_WAIT) ||
                  (state_q == S_UPDATE) || (state_q == S_FAIL);

  assign spi.spi_start = (state_q == S_START);
  assign spi.spi_cmd   = ANGLE_CMD;
  assign spi.spi_sel   = sel_on ? (N'(1) << idx_q) : '0;

  logic [11:0]        cur_ang;
  logic signed [31:0] cur_rev;
  logic signed [31:0] cur_off;
  logic               cur_seen;

  always_comb begin
    cur_ang  = '0;
    cur_rev  = '0;
    cur_off  = '0;
    cur_seen = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IW'(s)) begin
        cur_ang  = ang_q[s];
        cur_rev  = rev_q[s];
        cur_off  = off_q[s];
        cur_seen = seen_q[s];
      end
    end
  end

  logic signed [12:0] delta;
  logic signed [31:0] rev_d, abs_d, off_d, rel_d;
  logic               commit, fail;

  assign delta = $signed({1'b0, raw_q} - {1'b0, cur_ang});

  always_comb begin
    rev_d = cur_rev;
    if (cur_seen) begin
      if (delta > 13'sd2048)       rev_d = cur_rev - 32'sd1;
      else if (delta < -13'sd2048) rev_d = cur_rev + 32'sd1;
    end
  end

  // low 12 bits of rev*4096 are zero, so the add is a concatenation
  assign abs_d  = $signed({rev_d[19:0], raw_q});
  assign off_d  = zero_offset ? abs_d : cur_off;
  assign rel_d  = abs_d - off_d;
  assign commit = (state_q == S_UPDATE) && !bad_q;
  assign fail   = ((state_q == S_UPDATE) && bad_q) || (state_q == S_FAIL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      bad_q   <= 1'b0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      bad_q   <= bad_d;
      raw_q   <= raw_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      err_q  <= '0;
      seen_q <= '0;
      for (int s = 0; s < N; s++) begin
        ang_q[s] <= '0;
        abs_q[s] <= '0;
        off_q[s] <= '0;
        rel_q[s] <= '0;
        rev_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        if (idx_q == IW'(s)) begin
          if (commit) begin
            ang_q[s]  <= raw_q;
            abs_q[s]  <= abs_d;
            off_q[s]  <= off_d;
            rel_q[s]  <= rel_d;
            rev_q[s]  <= rev_d;
            seen_q[s] <= 1'b1;
            err_q[s]  <= 1'b0;
            cyc_q[s]  <= ~cyc_q[s];
          end else if (fail) begin
            err_q[s] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign sensor_angle[g]              = $signed({20'b0, ang_q[g]});
    assign sensor_angle_absolute[g]     = abs_q[g];
    assign sensor_angle_offset[g]       = off_q[g];
    assign sensor_angle_relative[g]     = rel_q[g];
    assign sensor_revolution_counter[g] = rev_q[g];
  end

  assign cycle = cyc_q;
  assign error = err_q;

endmodule

// File: tb/tb_a1339_poll_scheduler.sv
// Directed bench for a1339_poll_scheduler with a small SPI responder.
// Two sensors, 100-cycle poll period, 16-cycle timeout.
module tb_a1339_poll_scheduler;
  localparam int N  = 2;
  localparam int PD = 100;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic zero_offset;

  a1339_poll_scheduler_if #(.N(N)) spi ();

  logic signed [31:0] s_ang [N];
  logic signed [31:0] s_abs [N];
  logic signed [31:0] s_off [N];
  logic signed [31:0] s_rel [N];
  logic signed [31:0] s_rev [N];
  logic [N-1:0]       cyc;
  logic [N-1:0]       err;

  a1339_poll_scheduler #(
    .NUMBER_OF_SENSORS(N),
    .POLL_DIVIDER(PD),
    .TIMEOUT_CYCLES(TO),
    .ANGLE_CMD(16'h2000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .zero_offset(zero_offset),
    .spi(spi),
    .sensor_angle(s_ang),
    .sensor_angle_absolute(s_abs),
    .sensor_angle_offset(s_off),
    .sensor_angle_relative(s_rel),
    .sensor_revolution_counter(s_rev),
    .cycle(cyc),
    .error(err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  logic [15:0]  rsp [N];
  logic [N-1:0] mute;
  logic [N-1:0] sel_log [$];
  logic [N-1:0] exp_cyc;

  // SPI responder: answers 2 cycles into WAIT unless the sensor is muted
  initial begin
    int k;
    spi.spi_done = 1'b0;
    spi.spi_rx   = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset && spi.spi_start) begin
        k = spi.spi_sel[1] ? 1 : 0;
        sel_log.push_back(spi.spi_sel);
        if (!mute[k]) begin
          repeat (2) @(negedge clk);
          spi.spi_done = 1'b1;
          spi.spi_rx   = rsp[k];
          @(negedge clk);
          spi.spi_done = 1'b0;
          spi.spi_rx   = 16'h0;
        end
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (spi.spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL sweep_start: got no spi_start in 250 cycles, need 1");
    end
  endtask

  task automatic run_sweep();
    bit ok;
    wait_start(ok);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    enable      = 1'b1;
    zero_offset = 1'b0;
    mute        = '0;
    rsp[0]      = 16'h0123;
    rsp[1]      = 16'h0456;
    exp_cyc     = '0;
    repeat (3) @(negedge clk);
    ncmp++;
    if (s_ang[0] !== 32'sd0) begin
      nerr++;
      $display("FAIL rst_angle0: got %0d need 0", s_ang[0]);
    end
    ncmp++;
    if (s_abs[1] !== 32'sd0 || s_rev[1] !== 32'sd0) begin
      nerr++;
      $display("FAIL rst_abs_rev1: got %0d/%0d need 0/0", s_abs[1], s_rev[1]);
    end
    ncmp++;
    if (cyc !== 2'b00 || err !== 2'b00) begin
      nerr++;
      $display("FAIL rst_cyc_err: got %b/%b need 00/00", cyc, err);
    end
    ncmp++;
    if (spi.spi_sel !== 2'b00 || spi.spi_start !== 1'b0) begin
      nerr++;
      $display("FAIL rst_spi: got sel=%b start=%b need 00/0",
               spi.spi_sel, spi.spi_start);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sel_log.delete();
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (sel_log.size() != 2) begin
      nerr++;
      $display("FAIL sel_count: got %0d need 2", sel_log.size());
    end else begin
      ncmp++;
      if (sel_log[0] !== 2'b01 || sel_log[1] !== 2'b10) begin
        nerr++;
        $display("FAIL sel_order: got %b,%b need 01,10",
                 sel_log[0], sel_log[1]);
      end
    end
    ncmp++;
    if (s_ang[0] !== 32'sd291 || s_ang[1] !== 32'sd1110) begin
      nerr++;
      $display("FAIL basic_angle: got %0d,%0d need 291,1110",
               s_ang[0], s_ang[1]);
    end
    ncmp++;
    if (cyc !== exp_cyc || err !== 2'b00) begin
      nerr++;
      $display("FAIL basic_cyc_err: got %b/%b need %b/00", cyc, err, exp_cyc);
    end
    ncmp++;
    if (spi.spi_cmd !== 16'h2000) begin
      nerr++;
      $display("FAIL spi_cmd: got %h need 2000", spi.spi_cmd);
    end
  endtask

  task automatic test_revolution();
    rsp[0] = 16'd2000;
    rsp[1] = 16'd3158;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (s_rev[1] !== 32'sd0 || s_abs[1] !== 32'sd3158) begin
      nerr++;
      $display("FAIL delta_p2048: got rev=%0d abs=%0d need 0/3158",
               s_rev[1], s_abs[1]);
    end
    rsp[0] = 16'd4000;
    rsp[1] = 16'd1110;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (s_rev[1] !== 32'sd0 || s_abs[1] !== 32'sd1110) begin
      nerr++;
      $display("FAIL delta_m2048: got rev=%0d abs=%0d need 0/1110",
               s_rev[1], s_abs[1]);
    end
    ncmp++;
    if (s_rev[0] !== 32'sd0 || s_abs[0] !== 32'sd4000) begin
      nerr++;
      $display("FAIL rev_4000: got rev=%0d abs=%0d need 0/4000",
               s_rev[0], s_abs[0]);
    end
    rsp[0] = 16'd100;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (s_rev[0] !== 32'sd1 || s_abs[0] !== 32'sd4196 ||
        s_rel[0] !== 32'sd4196) begin
      nerr++;
      $display("FAIL rev_up: got rev=%0d abs=%0d rel=%0d need 1/4196/4196",
               s_rev[0], s_abs[0], s_rel[0]);
    end
    rsp[0] = 16'd4000;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (s_rev[0] !== 32'sd0 || s_abs[0] !== 32'sd4000) begin
      nerr++;
      $display("FAIL rev_down: got rev=%0d abs=%0d need 0/4000",
               s_rev[0], s_abs[0]);
    end
    ncmp++;
    if (cyc !== exp_cyc) begin
      nerr++;
      $display("FAIL rev_cycle: got %b need %b", cyc, exp_cyc);
    end
  endtask

  task automatic test_zero_offset();
    rsp[0] = 16'd2000;
    run_sweep();
    exp_cyc ^= 2'b11;
    zero_offset = 1'b1;
    rsp[0] = 16'd1000;
    run_sweep();
    exp_cyc ^= 2'b11;
    zero_offset = 1'b0;
    ncmp++;
    if (s_off[0] !== 32'sd1000 || s_rel[0] !== 32'sd0 ||
        s_off[1] !== 32'sd1110) begin
      nerr++;
      $display("FAIL zero_capture: got off0=%0d rel0=%0d off1=%0d need 1000/0/1110",
               s_off[0], s_rel[0], s_off[1]);
    end
    rsp[0] = 16'd1500;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (s_off[0] !== 32'sd1000 || s_rel[0] !== 32'sd500 ||
        s_abs[0] !== 32'sd1500) begin
      nerr++;
      $display("FAIL zero_rel: got off=%0d rel=%0d abs=%0d need 1000/500/1500",
               s_off[0], s_rel[0], s_abs[0]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    mute[0] = 1'b1;
    rsp[1]  = 16'd2222;
    sel_log.delete();
    wait_start(ok);
    repeat (TO + 1) @(negedge clk);
    ncmp++;
    if (err[0] !== 1'b0 || spi.spi_sel !== 2'b01) begin
      nerr++;
      $display("FAIL to_fail_cycle: got err0=%b sel=%b need 0/01",
               err[0], spi.spi_sel);
    end
    @(negedge clk);
    ncmp++;
    if (err[0] !== 1'b1 || spi.spi_sel !== 2'b00) begin
      nerr++;
      $display("FAIL to_next_cycle: got err0=%b sel=%b need 1/00",
               err[0], spi.spi_sel);
    end
    repeat (60) @(negedge clk);
    exp_cyc ^= 2'b10;
    ncmp++;
    if (s_ang[0] !== 32'sd1500 || s_abs[0] !== 32'sd1500) begin
      nerr++;
      $display("FAIL to_hold: got ang=%0d abs=%0d need 1500/1500",
               s_ang[0], s_abs[0]);
    end
    ncmp++;
    if (cyc !== exp_cyc || err !== 2'b01) begin
      nerr++;
      $display("FAIL to_cyc_err: got %b/%b need %b/01", cyc, err, exp_cyc);
    end
    ncmp++;
    if (s_abs[1] !== 32'sd2222 || s_rel[1] !== 32'sd1112 ||
        sel_log.size() != 2) begin
      nerr++;
      $display("FAIL to_next_sensor: got abs1=%0d rel1=%0d starts=%0d need 2222/1112/2",
               s_abs[1], s_rel[1], sel_log.size());
    end
    mute[0] = 1'b0;
  endtask

  task automatic test_bad_frame();
    rsp[0] = 16'd1500;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (err !== 2'b00) begin
      nerr++;
      $display("FAIL err_clear: got %b need 00", err);
    end
    rsp[0] = 16'h2123;
    rsp[1] = 16'h8123;
    run_sweep();
    ncmp++;
    if (err !== 2'b11 || cyc !== exp_cyc) begin
      nerr++;
      $display("FAIL bad_frame: got err=%b cyc=%b need 11/%b",
               err, cyc, exp_cyc);
    end
    ncmp++;
    if (s_ang[0] !== 32'sd1500 || s_ang[1] !== 32'sd2222) begin
      nerr++;
      $display("FAIL bad_hold: got %0d,%0d need 1500,2222",
               s_ang[0], s_ang[1]);
    end
    rsp[0] = 16'h0050;
    rsp[1] = 16'd2222;
    run_sweep();
    exp_cyc ^= 2'b11;
    ncmp++;
    if (err !== 2'b00 || s_ang[0] !== 32'sd80 || cyc !== exp_cyc) begin
      nerr++;
      $display("FAIL good_after_bad: got err=%b ang=%0d cyc=%b need 00/80/%b",
               err, s_ang[0], cyc, exp_cyc);
    end
    ncmp++;
    if (s_abs[0] !== 32'sd80 || s_rel[0] !== -32'sd920) begin
      nerr++;
      $display("FAIL rel_negative: got abs=%0d rel=%0d need 80/-920",
               s_abs[0], s_rel[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first;
    int starts;
    mute = 2'b11;
    wait_start(ok);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ncmp++;
    if (s_ang[0] !== 32'sd0 || s_rel[0] !== 32'sd0 || s_off[1] !== 32'sd0 ||
        cyc !== 2'b00 || spi.spi_sel !== 2'b00) begin
      nerr++;
      $display("FAIL mid_reset_clear: got ang0=%0d rel0=%0d off1=%0d cyc=%b sel=%b need zeros",
               s_ang[0], s_rel[0], s_off[1], cyc, spi.spi_sel);
    end
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (spi.spi_start) starts++;
    end
    ncmp++;
    if (starts != 0) begin
      nerr++;
      $display("FAIL mid_reset_start: got %0d starts need 0", starts);
    end
    mute   = 2'b00;
    rsp[0] = 16'd4000;
    rsp[1] = 16'd7;
    reset  = 1'b0;
    first  = -1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (spi.spi_start && first < 0) first = k;
    end
    ncmp++;
    if (first != PD) begin
      nerr++;
      $display("FAIL first_start: got cycle %0d need %0d", first, PD);
    end
    ncmp++;
    if (s_rev[0] !== 32'sd0 || s_abs[0] !== 32'sd4000 ||
        s_ang[1] !== 32'sd7 || cyc !== 2'b11) begin
      nerr++;
      $display("FAIL seen_reset: got rev0=%0d abs0=%0d ang1=%0d cyc=%b need 0/4000/7/11",
               s_rev[0], s_abs[0], s_ang[1], cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_revolution();
    test_zero_offset();
    test_timeout();
    test_bad_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
